// File: rtl/ysyx_24080014_npc_unit.sv
// Next-PC unit: owns the architectural PC and issues fetch requests over valid/ready.
// It selects the next PC on each EXU commit and also provides misalignment traps, halt and instret.
module ysyx_24080014_npc_unit #(
   parameter int               XLEN       = 32,
   parameter logic [XLEN-1:0]  RESET_PC   = 32'h8000_0000,
   parameter int               ILEN_BYTES = 4,
   parameter int               ALIGN_BITS = 2,
   parameter int               CNT_W      = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [XLEN-1:0]   pc,
   output logic              pc_valid,
   input  logic              pc_ready,
   input  logic              commit_valid,
   input  logic              commit_halt,
   input  logic [1:0]        csrs_ctl,
   input  logic [XLEN-1:0]   csr_next_pc,
   input  logic [1:0]        npc_ctr,
   input  logic [XLEN-1:0]   alu_out,
   input  logic [XLEN-1:0]   mtvec,
   output logic              misalign_valid,
   output logic [XLEN-1:0]   misalign_addr,
   output logic              halted,
   output logic [CNT_W-1:0]  instret
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [XLEN-1:0] LSB_CLR    = ~XLEN'(1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t             r_state;
   logic               r_boot;
   logic [XLEN-1:0]    r_pc;
   logic               r_pc_valid;
   logic               r_misalign_valid;
   logic [XLEN-1:0]    r_misalign_addr;
   logic               r_halted;
   logic [CNT_W-1:0]   r_instret;

   logic [XLEN-1:0]    w_seq;
   logic [XLEN-1:0]    w_tgt;
   logic               w_chk;
   logic               w_misalign;

   // CSR redirects bypass the alignment check; only jump targets are checked.
   always_comb begin
      w_seq = r_pc + XLEN'(ILEN_BYTES);
      w_tgt = w_seq;
      w_chk = 1'b0;
      if (csrs_ctl != 2'b00) begin
         w_tgt = csr_next_pc;
      end else begin
         case (npc_ctr)
            2'b01: begin
               w_tgt = alu_out & LSB_CLR;
               w_chk = 1'b1;
            end
            2'b10: w_tgt = w_seq;
            default: begin
               w_tgt = alu_out;
               w_chk = 1'b1;
            end
         endcase
      end
      w_misalign = w_chk && ((w_tgt & ALIGN_MASK) != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_boot           <= 1'b0;
         r_pc             <= RESET_PC;
         r_pc_valid       <= 1'b0;
         r_misalign_valid <= 1'b0;
         r_misalign_addr  <= '0;
         r_halted         <= 1'b0;
         r_instret        <= '0;
      end else begin
         r_misalign_valid <= 1'b0;
         case (r_state)
            // One full idle cycle after release before the first request.
            S_IDLE: begin
               if (r_boot) begin
                  r_state    <= S_FETCH;
                  r_pc_valid <= 1'b1;
               end else begin
                  r_boot <= 1'b1;
               end
            end
            S_FETCH: begin
               if (pc_ready) begin
                  r_state    <= S_EXEC;
                  r_pc_valid <= 1'b0;
               end
            end
            S_EXEC: begin
               if (commit_valid) begin
                  r_instret <= r_instret + CNT_W'(1);
                  if (w_misalign) begin
                     r_pc             <= mtvec;
                     r_misalign_valid <= 1'b1;
                     r_misalign_addr  <= w_tgt;
                  end else begin
                     r_pc <= w_tgt;
                  end
                  if (commit_halt) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state    <= S_FETCH;
                     r_pc_valid <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign pc             = r_pc;
   assign pc_valid       = r_pc_valid;
   assign misalign_valid = r_misalign_valid;
   assign misalign_addr  = r_misalign_addr;
   assign halted         = r_halted;
   assign instret        = r_instret;

endmodule

// File: tb/tb_ysyx_24080014_npc_unit.sv
// Randomized self-checking bench: two instances (ALIGN_BITS=2/CNT_W=64 and ALIGN_BITS=1/CNT_W=4)
// share stimulus and are each compared against a behavioural next-PC model.
module tb_ysyx_24080014_npc_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_ready = 1'b0;
   logic        commit_valid = 1'b0;
   logic        commit_halt = 1'b0;
   logic [1:0]  csrs_ctl = 2'b00;
   logic [31:0] csr_next_pc = '0;
   logic [1:0]  npc_ctr = 2'b10;
   logic [31:0] alu_out = '0;
   logic [31:0] mtvec = 32'h8000_0400;

   logic [31:0] pc_a, pc_b, maddr_a, maddr_b;
   logic        pv_a, pv_b, mv_a, mv_b, h_a, h_b;
   logic [63:0] ir_a;
   logic [3:0]  ir_b;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] m_pc[2];
   logic [63:0] m_cnt[2];
   logic [31:0] m_maddr[2];
   logic        m_mv[2];
   logic        m_halt;
   int          ab[2] = '{2, 1};
   logic [63:0] cmask[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF};

   always #5 clk = ~clk;

   ysyx_24080014_npc_unit dut_a (
      .clk(clk), .rst_n(rst_n), .pc(pc_a), .pc_valid(pv_a), .pc_ready(pc_ready),
      .commit_valid(commit_valid), .commit_halt(commit_halt), .csrs_ctl(csrs_ctl),
      .csr_next_pc(csr_next_pc), .npc_ctr(npc_ctr), .alu_out(alu_out), .mtvec(mtvec),
      .misalign_valid(mv_a), .misalign_addr(maddr_a), .halted(h_a), .instret(ir_a)
   );

   ysyx_24080014_npc_unit #(.ALIGN_BITS(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .pc(pc_b), .pc_valid(pv_b), .pc_ready(pc_ready),
      .commit_valid(commit_valid), .commit_halt(commit_halt), .csrs_ctl(csrs_ctl),
      .csr_next_pc(csr_next_pc), .npc_ctr(npc_ctr), .alu_out(alu_out), .mtvec(mtvec),
      .misalign_valid(mv_b), .misalign_addr(maddr_b), .halted(h_b), .instret(ir_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic reset_model();
      for (int i = 0; i < 2; i++) begin
         m_pc[i]    = 32'h8000_0000;
         m_cnt[i]   = '0;
         m_maddr[i] = '0;
         m_mv[i]    = 1'b0;
      end
      m_halt = 1'b0;
   endtask

   task automatic clear_pulse();
      m_mv[0] = 1'b0;
      m_mv[1] = 1'b0;
   endtask

   task automatic check_state(input string ph, input logic pv);
      chk({ph, ".pc_a"},    64'(pc_a),    64'(m_pc[0]));
      chk({ph, ".pv_a"},    64'(pv_a),    64'(pv));
      chk({ph, ".ir_a"},    ir_a,         m_cnt[0]);
      chk({ph, ".mv_a"},    64'(mv_a),    64'(m_mv[0]));
      chk({ph, ".maddr_a"}, 64'(maddr_a), 64'(m_maddr[0]));
      chk({ph, ".halt_a"},  64'(h_a),     64'(m_halt));
      chk({ph, ".pc_b"},    64'(pc_b),    64'(m_pc[1]));
      chk({ph, ".pv_b"},    64'(pv_b),    64'(pv));
      chk({ph, ".ir_b"},    64'(ir_b),    m_cnt[1]);
      chk({ph, ".mv_b"},    64'(mv_b),    64'(m_mv[1]));
      chk({ph, ".maddr_b"}, 64'(maddr_b), 64'(m_maddr[1]));
      chk({ph, ".halt_b"},  64'(h_b),     64'(m_halt));
   endtask

   task automatic model_commit(input logic [1:0] ctl, input logic [1:0] ctr, input logic [31:0] alu,
                               input logic [31:0] csr, input logic [31:0] mtv, input logic halt);
      for (int i = 0; i < 2; i++) begin
         logic [31:0] t;
         bit          need;
         if (ctl != 2'b00) begin
            t = csr; need = 0;
         end else if (ctr == 2'b10) begin
            t = m_pc[i] + 32'd4; need = 0;
         end else if (ctr == 2'b01) begin
            t = {alu[31:1], 1'b0}; need = 1;
         end else begin
            t = alu; need = 1;
         end
         if (need && (t % (32'd1 << ab[i])) != 0) begin
            m_pc[i] = mtv; m_mv[i] = 1'b1; m_maddr[i] = t;
         end else begin
            m_pc[i] = t; m_mv[i] = 1'b0;
         end
         m_cnt[i] = (m_cnt[i] + 64'd1) & cmask[i];
      end
      m_halt = halt;
   endtask

   // Called at a negedge while FETCH is expected; stalls, then hands off.
   task automatic fetch(input int stall);
      check_state("fetch", 1'b1);
      for (int s = 0; s < stall; s++) begin
         pc_ready     = 1'b0;
         commit_valid = 1'($urandom_range(0, 1));
         npc_ctr      = 2'($urandom);
         alu_out      = $urandom;
         @(negedge clk);
         commit_valid = 1'b0;
         clear_pulse();
         check_state("stall", 1'b1);
      end
      pc_ready = 1'b1;
      @(negedge clk);
      pc_ready = 1'b0;
      clear_pulse();
      check_state("handshake", 1'b0);
   endtask

   task automatic commit(input logic [1:0] ctl, input logic [1:0] ctr, input logic [31:0] alu,
                         input logic [31:0] csr, input logic [31:0] mtv, input logic halt,
                         input int delay);
      for (int d = 0; d < delay; d++) begin
         pc_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_state("exec", 1'b0);
      end
      csrs_ctl = ctl; npc_ctr = ctr; alu_out = alu; csr_next_pc = csr; mtvec = mtv;
      commit_halt  = halt;
      commit_valid = 1'b1;
      pc_ready     = 1'($urandom_range(0, 1));
      @(negedge clk);
      commit_valid = 1'b0;
      commit_halt  = 1'b0;
      pc_ready     = 1'b0;
      model_commit(ctl, ctr, alu, csr, mtv, halt);
      check_state("commit", !halt);
   endtask

   task automatic boot();
      @(negedge clk);
      rst_n    = 1'b1;
      pc_ready = 1'b1;
      @(negedge clk);
      check_state("idle", 1'b0);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] mtv;
      reset_model();
      @(negedge clk);
      @(negedge clk);
      check_state("reset", 1'b0);
      boot();

      mtv = 32'h8000_0400;
      fetch(0);
      commit(2'b00, 2'b10, $urandom, $urandom, mtv, 1'b0, 0);
      fetch(5);
      commit(2'b00, 2'b01, 32'h8000_1003, $urandom, mtv, 1'b0, 1);
      fetch(0);
      commit(2'b00, 2'b01, 32'h8000_0101, $urandom, mtv, 1'b0, 0);
      fetch(1);
      commit(2'b11, 2'b00, 32'h0000_0001, 32'h8000_0200, mtv, 1'b0, 2);

      for (int k = 0; k < 40; k++) begin
         fetch($urandom_range(0, 2));
         commit(2'($urandom), 2'($urandom), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
                1'b0, $urandom_range(0, 2));
      end

      fetch(0);
      commit(2'b00, 2'b00, 32'hFFFF_FFFC, $urandom, mtv, 1'b0, 0);
      fetch(0);
      commit(2'b00, 2'b10, $urandom, $urandom, mtv, 1'b0, 0);

      fetch(0);
      commit(2'b00, 2'b10, $urandom, $urandom, mtv, 1'b1, 0);
      for (int c = 0; c < 20; c++) begin
         pc_ready     = 1'($urandom_range(0, 1));
         commit_valid = 1'($urandom_range(0, 1));
         npc_ctr      = 2'($urandom);
         alu_out      = $urandom;
         @(negedge clk);
         clear_pulse();
         check_state("halt", 1'b0);
      end
      pc_ready = 1'b0;
      commit_valid = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      reset_model();
      check_state("async_reset", 1'b0);
      boot();
      for (int k = 0; k < 5; k++) begin
         fetch($urandom_range(0, 1));
         commit(2'($urandom), 2'($urandom), $urandom, $urandom, mtv, 1'b0, $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
